// File: rtl/uart_pkg.sv
// Shared encodings for the UART TX frame controller: FSM states, parity types, line levels.
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;
  localparam logic [2:0] ST_BRK    = 3'd6;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity for one TX word: XOR reduction of the data, inverted for odd parity.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);
  assign par = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: handshake, start/data/parity/stop sequencing, registered line output.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BREAK_LEN  = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  Data_accept,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = $clog2(max2(DATA_WIDTH, BREAK_LEN));
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] BRK_LAST  = CW'(BREAK_LEN - 1);

  logic [2:0]            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_sh;
  logic                  par_en_q, stop2_q, par_q, par_calc;
  logic                  tx_nxt, busy_nxt;
  logic                  win, brk_req, brk_go;
  logic [2:0]            tail_nxt;

`ifdef UART_TX_BREAK_EN
  assign brk_req = BREAK_REQ;
`else
  assign brk_req = 1'b0;
`endif

  // Accept window: idle, or the last stop cycle so frames can run back-to-back.
  assign win         = (state == ST_IDLE) || (state == ST_STOP1 && !stop2_q) || (state == ST_STOP2);
  assign brk_go      = win && brk_req;
  assign Data_accept = Data_valid && win && !brk_req;
  assign tail_nxt    = brk_go ? ST_BRK : (Data_accept ? ST_START : ST_IDLE);

  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par     (par_calc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      TX_OUT   <= LINE_IDLE;
      busy     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      TX_OUT <= tx_nxt;
      busy   <= busy_nxt;
      if (Data_accept) begin
        data_q   <= P_DATA;
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        par_q    <= par_calc;
      end else if (brk_go) begin
        stop2_q  <= STOP2;
      end
    end
  end

  // Counter only runs in DATA and BRK; it is zero on entry to either.
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    case (state)
      ST_IDLE:   state_nxt = tail_nxt;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (cnt == DATA_LAST) state_nxt = par_en_q ? ST_PARITY : ST_STOP1;
        else begin
          state_nxt = ST_DATA;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      ST_PARITY: state_nxt = ST_STOP1;
      ST_STOP1:  state_nxt = stop2_q ? ST_STOP2 : tail_nxt;
      ST_STOP2:  state_nxt = tail_nxt;
`ifdef UART_TX_BREAK_EN
      ST_BRK: begin
        if (cnt == BRK_LAST) state_nxt = ST_STOP1;
        else begin
          state_nxt = ST_BRK;
          cnt_nxt   = cnt + 1'b1;
        end
      end
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Line level is computed for the state being entered, so TX_OUT tracks the state register.
  assign data_sh = data_q >> cnt_nxt;

  always_comb begin
    tx_nxt   = LINE_IDLE;
    busy_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_START:  tx_nxt = LINE_START;
      ST_DATA:   tx_nxt = data_sh[0];
      ST_PARITY: tx_nxt = par_q;
      ST_STOP1:  tx_nxt = LINE_IDLE;
      ST_STOP2:  tx_nxt = LINE_IDLE;
`ifdef UART_TX_BREAK_EN
      ST_BRK:    tx_nxt = LINE_START;
`endif
      default:   tx_nxt = LINE_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Randomized self-checking bench for uart_tx_frame_ctrl against a frame-level reference model.
module tb_uart_tx_frame_ctrl;
  localparam int DW = 8;
  localparam int BL = 13;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic          BREAK_REQ = 1'b0;
`endif
  logic          Data_accept, TX_OUT, busy;

  int chk = 0;
  int pass = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .BREAK_LEN(BL)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .Data_valid  (Data_valid),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .STOP2       (STOP2),
`ifdef UART_TX_BREAK_EN
    .BREAK_REQ   (BREAK_REQ),
`endif
    .Data_accept (Data_accept),
    .TX_OUT      (TX_OUT),
    .busy        (busy)
  );

  // Reference frame: start 0, data LSB first, parity making the ones-count even/odd, stop bits.
  function automatic int model_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                                     input logic s2, output logic [63:0] bits);
    int n = 0;
    bits = '0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin bits[n] = d[i]; n++; end
    if (pe) begin bits[n] = ((($countones(d) % 2) == 1) != pt); n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  task automatic launch(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2,
                        output bit ok);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Data_accept) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1;
    Data_valid = 1'b0;
    P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
  endtask

  task automatic capture(input int n, output logic [63:0] tx, output logic [63:0] bz,
                         output logic [63:0] ac);
    tx = '0; bz = '0; ac = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tx[i] = TX_OUT; bz[i] = busy; ac[i] = Data_accept;
    end
  endtask

  task automatic test_reset;
    #12;
    chk++; if ({TX_OUT, busy, Data_accept} !== 3'b100) $display("FAIL reset_state got=%b want=100", {TX_OUT, busy, Data_accept}); else pass++;
    @(negedge CLK); RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk++; if ({TX_OUT, busy} !== 2'b10) $display("FAIL idle_after_reset got=%b want=10", {TX_OUT, busy}); else pass++;
  endtask

  task automatic test_fixed_a5;
    bit ok; logic [63:0] tx, bz, ac;
    launch(8'hA5, 1'b0, 1'b0, 1'b0, ok);
    chk++; if (!ok) $display("FAIL a5_accept timeout"); else pass++;
    capture(11, tx, bz, ac);
    chk++; if (tx[10:0] !== 11'h74A) $display("FAIL a5_line got=%h want=74a", tx[10:0]); else pass++;
    chk++; if (bz[10:0] !== 11'h3FF) $display("FAIL a5_busy got=%h want=3ff", bz[10:0]); else pass++;
    chk++; if (ac[10:0] !== 11'h000) $display("FAIL a5_extra_accept got=%h want=000", ac[10:0]); else pass++;
  endtask

  task automatic test_parity;
    bit ok; logic [63:0] tx, bz, ac, exp; int n;
    for (int t = 0; t < 2; t++) begin
      launch(8'h0F, 1'b1, 1'(t), 1'b0, ok);
      chk++; if (!ok) $display("FAIL par_accept timeout typ=%0d", t); else pass++;
      capture(12, tx, bz, ac);
      n = model_frame(8'h0F, 1'b1, 1'(t), 1'b0, exp);
      exp[n] = 1'b1;
      chk++; if (tx[9] !== 1'(t)) $display("FAIL par_bit typ=%0d got=%b want=%0d", t, tx[9], t); else pass++;
      chk++; if (tx[11:0] !== exp[11:0]) $display("FAIL par_line typ=%0d got=%h want=%h", t, tx[11:0], exp[11:0]); else pass++;
      chk++; if (bz[11:0] !== 12'h7FF) $display("FAIL par_busy typ=%0d got=%h want=7ff", t, bz[11:0]); else pass++;
    end
  endtask

  task automatic test_back_to_back;
    bit ok; logic [63:0] tx, bz, ac, e1, e2, exp; int n1, n2;
    @(posedge CLK); #1;
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; Data_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Data_accept) begin ok = 1'b1; break; end
    end
    chk++; if (!ok || busy !== 1'b0) $display("FAIL b2b_first_accept ok=%0d busy=%b want busy=0", ok, busy); else pass++;
    @(posedge CLK); #1;
    P_DATA = 8'h80;
    tx = '0; bz = '0; ac = '0;
    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      tx[i] = TX_OUT; bz[i] = busy; ac[i] = Data_accept;
      if (Data_accept) begin @(posedge CLK); #1; Data_valid = 1'b0; end
    end
    Data_valid = 1'b0;
    n1 = model_frame(8'h01, 1'b0, 1'b0, 1'b1, e1);
    n2 = model_frame(8'h80, 1'b0, 1'b0, 1'b1, e2);
    exp = e1 | (e2 << n1);
    exp[n1 + n2] = 1'b1;
    chk++; if (tx[22:0] !== exp[22:0]) $display("FAIL b2b_line got=%h want=%h", tx[22:0], exp[22:0]); else pass++;
    chk++; if (bz[22:0] !== 23'h3FFFFF) $display("FAIL b2b_busy got=%h want=3fffff", bz[22:0]); else pass++;
    chk++; if (ac[22:0] !== 23'h000400) $display("FAIL b2b_accept got=%h want=000400", ac[22:0]); else pass++;
  endtask

  task automatic test_random;
    bit ok; logic [63:0] tx, bz, ac, exp, m; int n;
    logic [DW-1:0] d; logic pe, pt, s2;
    for (int k = 0; k < 24; k++) begin
      d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      launch(d, pe, pt, s2, ok);
      n = model_frame(d, pe, pt, s2, exp);
      exp[n] = 1'b1;
      capture(n + 1, tx, bz, ac);
      m = (64'd1 << (n + 1)) - 64'd1;
      chk++;
      if (!ok || (tx & m) !== exp || (bz & m) !== ((64'd1 << n) - 64'd1))
        $display("FAIL rand_frame k=%0d d=%h pe=%0d pt=%0d s2=%0d ok=%0d line=%h want=%h busy=%h want=%h",
                 k, d, pe, pt, s2, ok, tx & m, exp, bz & m, (64'd1 << n) - 64'd1);
      else pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok; logic [63:0] tx, bz, ac, exp, m; int n; logic [DW-1:0] d;
    launch(8'h00, 1'b0, 1'b0, 1'b0, ok);
    capture(5, tx, bz, ac);
    chk++; if (!ok || tx[4] !== 1'b0 || bz[4] !== 1'b1) $display("FAIL mid_pre_reset line=%b busy=%b want 0 1", tx[4], bz[4]); else pass++;
    RST = 1'b0; #1;
    chk++; if ({TX_OUT, busy} !== 2'b10) $display("FAIL mid_reset_immediate got=%b want=10", {TX_OUT, busy}); else pass++;
    #2 RST = 1'b1;
    @(negedge CLK);
    chk++; if ({TX_OUT, busy} !== 2'b10) $display("FAIL mid_after_release got=%b want=10", {TX_OUT, busy}); else pass++;
    d = DW'($urandom);
    launch(d, 1'b1, 1'b0, 1'b1, ok);
    n = model_frame(d, 1'b1, 1'b0, 1'b1, exp);
    exp[n] = 1'b1;
    capture(n + 1, tx, bz, ac);
    m = (64'd1 << (n + 1)) - 64'd1;
    chk++; if (!ok || (tx & m) !== exp) $display("FAIL mid_clean_frame line=%h want=%h", tx & m, exp); else pass++;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    logic [63:0] tx, bz, ac, exp, m; int n;
    @(posedge CLK); #1;
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_valid = 1'b1; BREAK_REQ = 1'b1;
    @(negedge CLK);
    chk++; if (Data_accept !== 1'b0) $display("FAIL brk_accept_blocked got=%b want=0", Data_accept); else pass++;
    @(posedge CLK); #1; BREAK_REQ = 1'b0;
    tx = '0; bz = '0; ac = '0;
    for (int i = 0; i < BL + 1; i++) begin
      @(negedge CLK);
      tx[i] = TX_OUT; bz[i] = busy; ac[i] = Data_accept;
      if (Data_accept) begin @(posedge CLK); #1; Data_valid = 1'b0; end
    end
    Data_valid = 1'b0;
    chk++; if (tx[BL:0] !== (64'd1 << BL)) $display("FAIL brk_line got=%h want=%h", tx[BL:0], 64'd1 << BL); else pass++;
    chk++; if (bz[BL:0] !== ((64'd1 << (BL + 1)) - 1)) $display("FAIL brk_busy got=%h", bz[BL:0]); else pass++;
    chk++; if (ac[BL:0] !== (64'd1 << BL)) $display("FAIL brk_accept got=%h want=%h", ac[BL:0], 64'd1 << BL); else pass++;
    n = model_frame(8'h3C, 1'b0, 1'b0, 1'b0, exp);
    exp[n] = 1'b1;
    capture(n + 1, tx, bz, ac);
    m = (64'd1 << (n + 1)) - 64'd1;
    chk++; if ((tx & m) !== exp) $display("FAIL brk_then_frame line=%h want=%h", tx & m, exp); else pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fixed_a5;
    test_parity;
    test_back_to_back;
    test_random;
    test_reset_mid;
`ifdef UART_TX_BREAK_EN
    test_break;
`endif
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
